// File: rtl/stepgen_bank.sv
`default_nettype none
// ============================================================================
// Module : stepgen_bank
// Bank of independent step/dir pulse generators with endstop halt, signed
// position tracking and a registered status read port.
// Rev    : 1.0  initial release
// ============================================================================
module stepgen_bank #(
  parameter int CHANNELS = 12,
  parameter int PERIOD_W = 24,
  parameter int STEPS_W  = 32,
  parameter int POS_W    = 32,
  parameter int PULSE_W  = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [7:0]          reg_addr,
  input  logic [31:0]         reg_data,
  input  logic                reg_stb,
  input  logic [7:0]          rd_addr,
  output logic [31:0]         rd_data,
  input  logic [CHANNELS-1:0] endstop,
  output logic [CHANNELS-1:0] step,
  output logic [CHANNELS-1:0] dir,
  output logic [CHANNELS-1:0] enable_n,
  output logic [CHANNELS-1:0] busy,
  output logic [CHANNELS-1:0] done,
  output logic [CHANNELS-1:0] endstop_hit
);

  localparam int            c_pcnt_w     = $clog2(PULSE_W + 1);
  localparam [PERIOD_W-1:0] c_min_period = PERIOD_W'(PULSE_W + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_PULSE = 2'd2
  } state_t;

  logic [CHANNELS-1:0]            r_es_meta;
  logic [CHANNELS-1:0]            r_es_sync;
  logic [CHANNELS-1:0][3:0][31:0] w_rd_words;
  logic [31:0]                    w_rd_next;
  logic [STEPS_W-1:0]             w_wdata_steps;

  assign w_wdata_steps = STEPS_W'(reg_data);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_es_meta <= '0;
      r_es_sync <= '0;
    end else begin
      r_es_meta <= endstop;
      r_es_sync <= r_es_meta;
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    state_t              r_state, w_state_nxt;
    logic [PERIOD_W-1:0] r_period, r_cnt, w_eff;
    logic [STEPS_W-1:0]  r_steps;
    logic [POS_W-1:0]    r_pos;
    logic [c_pcnt_w-1:0] r_pcnt;
    logic r_dir, r_en, r_es_en, r_step, r_hit, r_done, r_halt;
    logic w_sel, w_wr_period, w_wr_steps, w_wr_ctrl, w_wr_pos;
    logic w_stop_req, w_busy, w_start, w_fire, w_es_stop, w_end;

    assign w_sel       = reg_stb && (reg_addr[7:2] == 6'(g));
    assign w_wr_period = w_sel && (reg_addr[1:0] == 2'd0);
    assign w_wr_steps  = w_sel && (reg_addr[1:0] == 2'd1);
    assign w_wr_ctrl   = w_sel && (reg_addr[1:0] == 2'd2);
    assign w_wr_pos    = w_sel && (reg_addr[1:0] == 2'd3);
    // Abort bit or dropping enable both request a halt of the running move.
    assign w_stop_req  = w_wr_ctrl && (reg_data[3] || !reg_data[1]);
    assign w_busy      = (r_state != S_IDLE);
    assign w_eff       = (r_period < c_min_period) ? c_min_period : r_period;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
    end

    always_comb begin
      w_state_nxt = r_state;
      w_start     = 1'b0;
      w_fire      = 1'b0;
      w_es_stop   = 1'b0;
      w_end       = 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_wr_steps && (w_wdata_steps != '0) && r_en) begin
            w_start     = 1'b1;
            w_state_nxt = S_WAIT;
          end
        end
        S_WAIT: begin
          if (w_stop_req) begin
            w_end       = 1'b1;
            w_state_nxt = S_IDLE;
          end else if (r_cnt == PERIOD_W'(1)) begin
            if (r_es_en && !r_dir && r_es_sync[g]) begin
              w_es_stop   = 1'b1;
              w_end       = 1'b1;
              w_state_nxt = S_IDLE;
            end else begin
              w_fire      = 1'b1;
              w_state_nxt = S_PULSE;
            end
          end
        end
        S_PULSE: begin
          if (r_pcnt == '0) begin
            if (r_halt || w_stop_req || (r_steps == '0)) begin
              w_end       = 1'b1;
              w_state_nxt = S_IDLE;
            end else begin
              w_state_nxt = S_WAIT;
            end
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end

    // Start loads P-1 because the rise lands one cycle after the expiry
    // decision; later reloads happen on the rise itself and use P.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_period <= '0;
        r_cnt    <= '0;
        r_steps  <= '0;
        r_pos    <= '0;
        r_pcnt   <= '0;
        r_dir    <= 1'b0;
        r_en     <= 1'b0;
        r_es_en  <= 1'b0;
        r_step   <= 1'b0;
        r_hit    <= 1'b0;
        r_done   <= 1'b0;
        r_halt   <= 1'b0;
      end else begin
        r_done <= w_end;
        if (w_wr_period) r_period <= PERIOD_W'(reg_data);
        if (w_wr_ctrl) begin
          r_en <= reg_data[1];
          if (!w_busy) begin
            r_dir   <= reg_data[0];
            r_es_en <= reg_data[2];
          end
        end
        if (w_wr_pos && !w_busy) r_pos <= POS_W'($signed(reg_data));

        if (w_start) begin
          r_steps <= w_wdata_steps;
          r_hit   <= 1'b0;
          r_halt  <= 1'b0;
          r_cnt   <= w_eff - PERIOD_W'(1);
        end else if (w_fire) begin
          r_cnt   <= w_eff;
          r_steps <= r_steps - STEPS_W'(1);
          r_pos   <= r_dir ? (r_pos + POS_W'(1)) : (r_pos - POS_W'(1));
          r_step  <= 1'b1;
          r_pcnt  <= c_pcnt_w'(PULSE_W - 1);
        end else if (w_busy) begin
          r_cnt <= r_cnt - PERIOD_W'(1);
        end

        if (r_state == S_PULSE) begin
          if (r_pcnt == '0) begin
            r_step <= 1'b0;
            r_halt <= 1'b0;
          end else begin
            r_pcnt <= r_pcnt - c_pcnt_w'(1);
            if (w_stop_req) r_halt <= 1'b1;
          end
        end
        if (w_es_stop) r_hit <= 1'b1;
      end
    end

    assign step[g]        = r_step;
    assign dir[g]         = r_dir;
    assign enable_n[g]    = ~r_en;
    assign busy[g]        = w_busy;
    assign done[g]        = r_done;
    assign endstop_hit[g] = r_hit;

    assign w_rd_words[g][0] = 32'(r_period);
    assign w_rd_words[g][1] = 32'(r_steps);
    assign w_rd_words[g][2] = {26'd0, w_busy, r_hit, r_es_sync[g], r_es_en, r_en, r_dir};
    assign w_rd_words[g][3] = 32'($signed(r_pos));
  end

  // Channel indices beyond the bank never match, so they read as zero.
  always_comb begin
    w_rd_next = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (rd_addr[7:2] == 6'(i)) w_rd_next = w_rd_words[i][rd_addr[1:0]];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_data <= '0;
    else        rd_data <= w_rd_next;
  end

endmodule
`default_nettype wire
